// File: rtl/onewire_master.sv
// 1-wire bus master: issues reset/presence, write and read slots timed by a 1 us tick.
// Optional macro ONEWIRE_SYNC_EN adds a 2-flop synchronizer on BUS_IN.
module onewire_master #(
    parameter int TICK_DIV = 29
) (
    input  logic C,
    input  logic CLR,
    input  logic CMD_RESET,
    input  logic CMD_WRITE,
    input  logic CMD_READ,
    input  logic WDATA,
    input  logic BUS_IN,
    output logic BUS_LOW,
    output logic BUSY,
    output logic DONE,
    output logic RDATA,
    output logic PRESENCE
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RELEASE} state_e;
    typedef enum logic [1:0] {K_RESET, K_WRITE, K_READ} kind_e;

    localparam logic [7:0] PRESC_LAST   = 8'(TICK_DIV - 1);
    localparam logic [9:0] READ_SAMPLE  = 10'd15;
    localparam logic [9:0] RESET_SAMPLE = 10'd550;

    state_e     state_q, state_d;
    kind_e      kind_q, kind_d;
    logic [7:0] presc_q, presc_d;
    logic [9:0] us_q, us_d;
    logic       wbit_q, wbit_d;
    logic       bus_low_q, bus_low_d;
    logic       done_q, done_d;
    logic       rdata_q, rdata_d;
    logic       presence_q, presence_d;

    logic       tick;
    logic [9:0] us_next;
    logic [9:0] low_time;
    logic [9:0] slot_time;
    logic       bus_s;

`ifdef ONEWIRE_SYNC_EN
    logic [1:0] sync_q;

    // Reset to 1 so an idle (pulled-up) line is seen until real samples arrive.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], BUS_IN};
    end
    assign bus_s = sync_q[1];
`else
    assign bus_s = BUS_IN;
`endif

    assign tick    = (presc_q == PRESC_LAST);
    assign us_next = us_q + 10'd1;

    always_comb begin
        low_time  = 10'd6;
        slot_time = 10'd70;
        case (kind_q)
            K_RESET: begin
                low_time  = 10'd480;
                slot_time = 10'd960;
            end
            K_WRITE: low_time = wbit_q ? 10'd6 : 10'd60;
            default: low_time = 10'd6;
        endcase
    end

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        wbit_d     = wbit_q;
        presc_d    = 8'd0;
        us_d       = 10'd0;
        done_d     = 1'b0;
        rdata_d    = rdata_q;
        presence_d = presence_q;

        case (state_q)
            S_IDLE: begin
                if (CMD_RESET) begin
                    kind_d  = K_RESET;
                    state_d = S_DRIVE;
                end else if (CMD_WRITE) begin
                    kind_d  = K_WRITE;
                    wbit_d  = WDATA;
                    state_d = S_DRIVE;
                end else if (CMD_READ) begin
                    kind_d  = K_READ;
                    state_d = S_DRIVE;
                end
            end
            default: begin
                presc_d = tick ? 8'd0 : presc_q + 8'd1;
                us_d    = tick ? us_next : us_q;
                if (tick) begin
                    if (kind_q == K_READ && us_next == READ_SAMPLE)
                        rdata_d = bus_s;
                    if (kind_q == K_RESET && us_next == RESET_SAMPLE)
                        presence_d = ~bus_s;
                    if (state_q == S_DRIVE && us_next == low_time)
                        state_d = S_RELEASE;
                    if (state_q == S_RELEASE && us_next == slot_time) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase

        bus_low_d = (state_d == S_DRIVE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q    <= S_IDLE;
            kind_q     <= K_RESET;
            wbit_q     <= 1'b0;
            presc_q    <= 8'd0;
            us_q       <= 10'd0;
            bus_low_q  <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= 1'b0;
            presence_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            wbit_q     <= wbit_d;
            presc_q    <= presc_d;
            us_q       <= us_d;
            bus_low_q  <= bus_low_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            presence_q <= presence_d;
        end
    end

    assign BUS_LOW  = bus_low_q;
    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = done_q;
    assign RDATA    = rdata_q;
    assign PRESENCE = presence_q;

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master at TICK_DIV=4 (4 cycles per us) with a wired-AND bus model.
module tb_onewire_master;

    logic C = 1'b0;
    logic CLR;
    logic CMD_RESET, CMD_WRITE, CMD_READ, WDATA;
    logic BUS_IN, BUS_LOW, BUSY, DONE, RDATA, PRESENCE;
    logic model_pull;

    int errors = 0;
    int checks = 0;

    onewire_master #(.TICK_DIV(4)) dut (
        .C(C), .CLR(CLR),
        .CMD_RESET(CMD_RESET), .CMD_WRITE(CMD_WRITE), .CMD_READ(CMD_READ),
        .WDATA(WDATA), .BUS_IN(BUS_IN),
        .BUS_LOW(BUS_LOW), .BUSY(BUSY), .DONE(DONE),
        .RDATA(RDATA), .PRESENCE(PRESENCE)
    );

    always #5 C = ~C;

    // Open-drain line with pull-up: low if master or device pulls.
    assign BUS_IN = ~(BUS_LOW | model_pull);

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issues one command at a negedge and follows the slot; index k = posedges since accept.
    // pull_a/pull_b: device pulls the line for us in [pull_a, pull_b).
    task automatic run_slot(input logic r, input logic w, input logic wd, input logic rd,
                            input int pull_a, input int pull_b, input bit inject,
                            output int high, output int done_idx, output int dones,
                            output int busy_at_done, output int busy_after);
        high = 0; done_idx = 0; dones = 0; busy_at_done = -1; busy_after = 0;
        @(negedge C);
        CMD_RESET = r; CMD_WRITE = w; WDATA = wd; CMD_READ = rd;
        for (int k = 0; k < 5000; k++) begin
            @(negedge C);
            if (k == 0) begin
                CMD_RESET = 0; CMD_WRITE = 0; CMD_READ = 0;
            end
            if (inject && k == 100) begin CMD_WRITE = 1; WDATA = 1; end
            if (inject && k == 101) CMD_WRITE = 0;
            if (BUS_LOW) high++;
            if (DONE) begin
                dones++;
                if (done_idx == 0) begin
                    done_idx     = k + 1;
                    busy_at_done = BUSY;
                end
            end else if (done_idx != 0 && BUSY) begin
                busy_after = 1;
            end
            model_pull = (k + 1 >= 4 * pull_a) && (k + 1 < 4 * pull_b);
            if (done_idx != 0 && k >= done_idx + 10) break;
        end
        model_pull = 0;
    endtask

    int high, done_idx, dones, busy_at_done, busy_after;
    int stray_done;

    initial begin
        CLR = 1; CMD_RESET = 0; CMD_WRITE = 0; CMD_READ = 0; WDATA = 0; model_pull = 0;
        repeat (3) @(negedge C);
        check("rst_bus_low", BUS_LOW, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_presence", PRESENCE, 0);
        CLR = 0;

        // Write-0 with an extra CMD_WRITE injected while busy.
        run_slot(0, 1, 0, 0, 0, 0, 1, high, done_idx, dones, busy_at_done, busy_after);
        check("w0_low_cycles", high, 240);
        check("w0_done_cycle", done_idx, 281);
        check("w0_release_cycles", done_idx - 1 - high, 40);
        check("w0_busy_at_done", busy_at_done, 0);
        check("w0_single_done", dones, 1);
        check("w0_not_queued", busy_after, 0);

        run_slot(0, 1, 1, 0, 0, 0, 0, high, done_idx, dones, busy_at_done, busy_after);
        check("w1_low_cycles", high, 24);
        check("w1_done_cycle", done_idx, 281);

        run_slot(0, 0, 0, 1, 0, 30, 0, high, done_idx, dones, busy_at_done, busy_after);
        check("rd_held_low_cycles", high, 24);
        check("rd_held_rdata", RDATA, 0);
        check("rd_held_done_cycle", done_idx, 281);

        run_slot(0, 0, 0, 1, 0, 8, 0, high, done_idx, dones, busy_at_done, busy_after);
        check("rd_rel_low_cycles", high, 24);
        check("rd_rel_rdata", RDATA, 1);

        // Reset and read together: reset slot only, no device present.
        run_slot(1, 0, 0, 1, 0, 0, 0, high, done_idx, dones, busy_at_done, busy_after);
        check("rr_low_cycles", high, 1920);
        check("rr_done_cycle", done_idx, 3841);
        check("rr_presence", PRESENCE, 0);
        check("rr_rdata_kept", RDATA, 1);
        check("rr_single_done", dones, 1);

        run_slot(1, 0, 0, 0, 500, 620, 0, high, done_idx, dones, busy_at_done, busy_after);
        check("rst_slot_low_cycles", high, 1920);
        check("rst_slot_presence", PRESENCE, 1);
        check("rst_slot_rdata_kept", RDATA, 1);

        run_slot(0, 1, 0, 0, 0, 0, 0, high, done_idx, dones, busy_at_done, busy_after);
        check("wr_presence_kept", PRESENCE, 1);

        // Abort a reset slot at US=200 with CLR.
        @(negedge C);
        CMD_RESET = 1;
        @(negedge C);
        CMD_RESET = 0;
        repeat (799) @(negedge C);
        check("abort_pre_bus_low", BUS_LOW, 1);
        CLR = 1;
        #1;
        check("abort_bus_low", BUS_LOW, 0);
        check("abort_busy", BUSY, 0);
        check("abort_rdata", RDATA, 0);
        check("abort_presence", PRESENCE, 0);
        @(negedge C);
        CLR = 0;
        stray_done = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge C);
            if (DONE || BUSY || BUS_LOW) stray_done++;
        end
        check("abort_no_done", stray_done, 0);

        run_slot(0, 0, 0, 1, 0, 8, 0, high, done_idx, dones, busy_at_done, busy_after);
        check("post_abort_low_cycles", high, 24);
        check("post_abort_done_cycle", done_idx, 281);
        check("post_abort_rdata", RDATA, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onewire_master.md
ONEWIRE_MASTER -- requirements
Module: onewire_master

Interface
REQ-001 SHALL have parameter TICK_DIV, default 29, meaning clock cycles per 1 us timing tick, legal range 2..255.
REQ-002 SHALL have port C  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port CLR  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port CMD_RESET  input  1  request bus reset/presence slot.
REQ-005 SHALL have port CMD_WRITE  input  1  request write slot of bit WDATA.
REQ-006 SHALL have port CMD_READ  input  1  request read slot.
REQ-007 SHALL have port WDATA  input  1  bit to write, sampled with CMD_WRITE.
REQ-008 SHALL have port BUS_IN  input  1  1-wire line level from IBUF.
REQ-009 SHALL have port BUS_LOW  output  1  1 = pull line low; drives OBUFT T-inverted open-drain pad.
REQ-010 SHALL have port BUSY  output  1  slot in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse at slot end.
REQ-012 SHALL have port RDATA  output  1  last sampled read bit.
REQ-013 SHALL have port PRESENCE  output  1  1 = device answered last reset slot.

Function
REQ-014 SHALL contain a prescaler counting 0..TICK_DIV-1 producing a 1-cycle tick on terminal count, and a 10-bit microsecond counter US advanced on tick.
REQ-015 SHALL in IDLE accept a command when BUSY=0; priority CMD_RESET > CMD_WRITE > CMD_READ; commands while BUSY=1 ignored, not queued.
REQ-016 SHALL on accept clear prescaler and US, latch slot type and WDATA, assert BUSY and BUS_LOW from next cycle.
REQ-017 SHALL implement states IDLE -> DRIVE -> RELEASE -> IDLE; DRIVE ends (BUS_LOW=0) when US reaches low time, RELEASE ends when US reaches slot time.
REQ-018 SHALL use low/slot times (us): reset 480/960; write-1 6/70; write-0 60/70; read 6/70.
REQ-019 SHALL sample BUS_IN into RDATA at US=15 of read slot; sample at US=550 of reset slot, PRESENCE = ~BUS_IN.
REQ-020 SHALL on leaving RELEASE deassert BUSY and pulse DONE for exactly one cycle; new command accepted in cycle after DONE.
REQ-021 SHALL leave RDATA unchanged by write/reset slots and PRESENCE unchanged by read/write slots.
REQ-022 SHALL hold BUS_LOW=0 in IDLE and RELEASE; BUS_LOW is registered, glitch-free.

Reset
REQ-023 SHALL on CLR=1 immediately force IDLE, BUS_LOW=0, BUSY=0, DONE=0, RDATA=0, PRESENCE=0, counters 0, regardless of slot in progress.
REQ-024 SHALL not emit DONE for a slot aborted by CLR.

Configuration
REQ-025 SHALL honour macro ONEWIRE_SYNC_EN: defined -> BUS_IN passes a 2-flop synchronizer (reset 1) before sampling, sample points unchanged in US terms; undefined -> BUS_IN sampled directly.

Verification
REQ-026 TICK_DIV=4, CMD_WRITE WDATA=0 -> BUS_LOW high 240 cycles, low 40 cycles, DONE at cycle 281, BUSY cleared same cycle.
REQ-027 TICK_DIV=4, CMD_READ, BUS_IN low for first 30 us -> RDATA=0; BUS_IN released after 8 us -> RDATA=1; BUS_LOW high 24 cycles both.
REQ-028 TICK_DIV=4, CMD_RESET, model pulls low 500..620 us -> BUS_LOW high 1920 cycles, PRESENCE=1; no model -> PRESENCE=0.
REQ-029 CMD_RESET+CMD_READ same cycle -> reset slot only; CMD_WRITE during BUSY -> ignored, single DONE.
REQ-030 CLR pulse at US=200 of reset slot -> BUS_LOW=0 same cycle, no DONE, next CMD_READ runs normal 70 us slot.
